register_file_param: RTL
========================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, address bits; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have ports:
  clk  input  1  single clock, rising edge; all state clocked here.
  reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
  we_a  input  1  write-port A enable.
  waddr_a  input  ADDR_WIDTH  write-port A address.
  wdata_a  input  DATA_WIDTH  write-port A data.
  we_b  input  1  write-port B enable.
  waddr_b  input  ADDR_WIDTH  write-port B address.
  wdata_b  input  DATA_WIDTH  write-port B data.
  raddr_a  input  ADDR_WIDTH  read-port A address.
  raddr_b  input  ADDR_WIDTH  read-port B address.
  clear_start  input  1  request a sequential clear of all registers.
  rdata_a  output  DATA_WIDTH  registered read-port A data.
  rdata_b  output  DATA_WIDTH  registered read-port B data.
  busy  output  1  high while a clear is in progress.
  clear_done  output  1  one-cycle pulse when the clear finishes.
  wr_collision  output  1  one-cycle pulse when both ports write the same address.

Function
REQ-005 Reads SHALL have 1-cycle latency: rdata_x at edge N+1 reflects raddr_x sampled at edge N.
REQ-006 Reads SHALL forward same-cycle writes: if a write to raddr_x is accepted at edge N, rdata_x after edge N SHALL equal the written data, not the old contents.
REQ-007 Writes SHALL commit at the rising edge when the enable is high and the FSM is IDLE.
REQ-008 If we_a and we_b are both high with waddr_a == waddr_b, port B data SHALL be stored and forwarded, and wr_collision SHALL pulse high for exactly one cycle.
REQ-009 wr_collision SHALL be evaluated even when ZERO_REG=1 and address 0 is targeted; it SHALL NOT assert during CLEAR.
REQ-010 With ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0, including the forwarding path.
REQ-011 The clear FSM SHALL have states IDLE and CLEAR.
REQ-012 IDLE -> CLEAR on clear_start=1; the clear counter SHALL load 0 and busy SHALL be high from the next cycle.
REQ-013 In CLEAR, the FSM SHALL zero register[counter] at each edge and increment the counter; a clear SHALL take exactly DEPTH cycles.
REQ-014 When the counter equals DEPTH-1, the FSM SHALL write that register, return to IDLE, and pulse clear_done for one cycle coincident with busy falling.
REQ-015 In CLEAR, we_a/we_b SHALL be ignored (data dropped) and clear_start SHALL be ignored.
REQ-016 Reads in CLEAR SHALL return stored contents; forwarding SHALL reflect the clear write (zero) when raddr matches the counter.
REQ-017 A clear_start arriving simultaneously with writes in IDLE SHALL let the writes commit and start the clear.
REQ-018 The counter SHALL be ADDR_WIDTH+1 bits wide or compare before wrap, so it never silently wraps past DEPTH-1.

Reset
REQ-019 While reset=0, all registers SHALL be 0, rdata_a=rdata_b=0, busy=0, clear_done=0, wr_collision=0, FSM=IDLE, counter=0.
REQ-020 Reset asserted mid-clear SHALL abort immediately to the reset state; no clear_done pulse SHALL be produced.
REQ-021 Reset SHALL take effect without a clock edge; release is synchronous to the first subsequent clk edge.

Structure
REQ-022 The FSM state encoding (IDLE, CLEAR) and default parameter constants SHALL live in a shared package, regfile_pkg.
REQ-023 The clear sequencer (FSM plus counter, busy, clear_done) SHALL be a sub-module, regfile_clear_seq; storage, write arbitration and read forwarding SHALL stay in the top level.

Verification
REQ-024 Reset, write A addr1=0x5A; next cycle read A addr1 -> rdata_a=0x5A one cycle later; rdata_b on addr0 = 0x00.
REQ-025 Same-cycle we_a addr2=0x11 and we_b addr2=0x22 with raddr_a=2 -> rdata_a=0x22 after the edge, wr_collision pulses once, addr2 holds 0x22.
REQ-026 Fill regs 0..3 with 0xFF, pulse clear_start -> busy high for exactly 4 cycles, clear_done pulses on the 4th, all reads 0x00 afterwards; a write of 0x33 issued during busy is absent.
REQ-027 ZERO_REG=1: write addr0=0x77 -> read addr0 = 0x00 both registered and forwarded.
REQ-028 Start a clear, assert reset=0 after 2 cycles -> busy=0 immediately, no clear_done, all registers 0.
REQ-029 DATA_WIDTH=16, ADDR_WIDTH=3: write addr7=0xBEEF -> read 0xBEEF; clear takes 8 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the parameterised register file: default geometry
// and the encoding of the clear-sequencer states.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_ZERO_REG   = 0;

    // Clear sequencer state encoding (kept as plain constants so older
    // tooling and netlist scripts can match the raw codes).
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks a counter over every register address, one per
// clock, while the register file is being zeroed. Exposes the current
// clear address, a busy flag and a one-cycle completion pulse.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  clear_active,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  busy,
    output logic                  clear_done
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    // One extra counter bit so the final-address compare can never be
    // bypassed by a silent wrap back to zero.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic [ADDR_WIDTH:0] cnt_r;
    logic [ADDR_WIDTH:0] cnt_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;
    logic                done_r;
    logic                done_nxt_s;

    // Next-state, counter and flag decode for the IDLE/CLEAR sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = '0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = '0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers; an asserted reset aborts any clear at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign clear_active = (state_r == ST_CLEAR);
    assign clear_addr   = cnt_r[ADDR_WIDTH-1:0];
    assign busy         = busy_r;
    assign clear_done   = done_r;

endmodule : regfile_clear_seq

// File: rtl/register_file_param.sv
// Two-write / two-read register file with registered read data, write-to-
// read forwarding, port-B-wins collision handling, optional hardwired zero
// register and a sequential clear driven by regfile_clear_seq.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    input  logic                  clear_start,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  wr_collision
);

    localparam int   DEPTH   = 1 << ADDR_WIDTH;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_r;
    logic [DATA_WIDTH-1:0] rdata_b_r;
    logic                  collision_r;

    logic                  clear_active_s;
    logic [ADDR_WIDTH-1:0] clear_addr_s;
    logic                  idle_s;
    logic                  same_waddr_s;
    logic                  wr_a_ok_s;
    logic                  wr_b_ok_s;
    logic                  collision_s;
    logic [DATA_WIDTH-1:0] rd_a_nxt_s;
    logic [DATA_WIDTH-1:0] rd_b_nxt_s;

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk          (clk),
        .reset        (reset),
        .clear_start  (clear_start),
        .clear_active (clear_active_s),
        .clear_addr   (clear_addr_s),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    // Write arbitration: writes only land while idle; on an address clash
    // port B wins, and the zero register silently drops its writes. The
    // collision flag ignores the zero register so clashes on it still show.
    always_comb begin
        idle_s       = !clear_active_s;
        same_waddr_s = (waddr_a == waddr_b);
        collision_s  = idle_s && we_a && we_b && same_waddr_s;
        wr_b_ok_s    = idle_s && we_b && !(ZERO_EN && (waddr_b == '0));
        wr_a_ok_s    = idle_s && we_a && !(we_b && same_waddr_s)
                       && !(ZERO_EN && (waddr_a == '0));
    end

    // Read-port data selection with forwarding of this cycle's write; a
    // clear in progress forwards zero for the register being cleared.
    always_comb begin
        if (clear_active_s && (raddr_a == clear_addr_s)) begin
            rd_a_nxt_s = '0;
        end else if (ZERO_EN && (raddr_a == '0)) begin
            rd_a_nxt_s = '0;
        end else if (wr_b_ok_s && (waddr_b == raddr_a)) begin
            rd_a_nxt_s = wdata_b;
        end else if (wr_a_ok_s && (waddr_a == raddr_a)) begin
            rd_a_nxt_s = wdata_a;
        end else begin
            rd_a_nxt_s = regs_r[raddr_a];
        end

        if (clear_active_s && (raddr_b == clear_addr_s)) begin
            rd_b_nxt_s = '0;
        end else if (ZERO_EN && (raddr_b == '0)) begin
            rd_b_nxt_s = '0;
        end else if (wr_b_ok_s && (waddr_b == raddr_b)) begin
            rd_b_nxt_s = wdata_b;
        end else if (wr_a_ok_s && (waddr_a == raddr_b)) begin
            rd_b_nxt_s = wdata_a;
        end else begin
            rd_b_nxt_s = regs_r[raddr_b];
        end
    end

    // Register storage: the clear owns the array while active, otherwise
    // the arbitrated port writes commit (never to the same entry).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (clear_active_s) begin
            regs_r[clear_addr_s] <= '0;
        end else begin
            if (wr_a_ok_s) begin
                regs_r[waddr_a] <= wdata_a;
            end
            if (wr_b_ok_s) begin
                regs_r[waddr_b] <= wdata_b;
            end
        end
    end

    // Registered read data and collision pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_a_r   <= '0;
            rdata_b_r   <= '0;
            collision_r <= 1'b0;
        end else begin
            rdata_a_r   <= rd_a_nxt_s;
            rdata_b_r   <= rd_b_nxt_s;
            collision_r <= collision_s;
        end
    end

    assign rdata_a      = rdata_a_r;
    assign rdata_b      = rdata_b_r;
    assign wr_collision = collision_r;

endmodule : register_file_param
